// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with a registered output, explicit-select or round-robin grant.
// Optional handshake counter on output port beat_cnt when STREAM_MUX_BEAT_CNT_EN is defined.

module stream_mux_rr_lane #(
    parameter int              SW = 2,
    parameter logic [SW-1:0]   ID = '0
) (
    input  logic          en,
    input  logic [SW-1:0] grant,
    output logic          ready
);
    assign ready = en && (grant == ID);
endmodule

module stream_mux_rr #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
`ifdef STREAM_MUX_BEAT_CNT_EN
    output logic [15:0]    beat_cnt,
`endif
    output logic           sel_err,
    input  logic           clr_err
);
    localparam logic [SW:0]   N_L  = (SW+1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic          load_en;
    logic          sel_ok;
    logic          grant_valid;
    logic          accept;
    logic [SW-1:0] grant;
    logic [SW-1:0] rr_ptr;
    logic [SW:0]   cand;
    logic [W-1:0]  grant_data;

    assign load_en = !out_valid || out_ready;
    assign sel_ok  = {1'b0, sel} < N_L;
    assign accept  = rst_n && load_en && grant_valid;

    // Round-robin scans from rr_ptr upward, wrapping at N.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        if (!mode) begin
            if (sel_ok && in_valid[sel]) begin
                grant_valid = 1'b1;
                grant       = sel;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cand = {1'b0, rr_ptr} + (SW+1)'(i);
                if (cand >= N_L) cand = cand - N_L;
                if (!grant_valid && in_valid[cand[SW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant       = cand[SW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SW'(k)) grant_data = in_data[k*W +: W];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        stream_mux_rr_lane #(.SW(SW), .ID(SW'(k))) u_lane (
            .en    (accept),
            .grant (grant),
            .ready (in_ready[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant;
                if (mode) rr_ptr <= (grant == LAST) ? '0 : grant + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Set has priority over clear so a persisting bad sel is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                sel_err <= 1'b0;
        else if (!mode && !sel_ok) sel_err <= 1'b1;
        else if (clr_err)          sel_err <= 1'b0;
    end

`ifdef STREAM_MUX_BEAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      beat_cnt <= '0;
        else if (clr_err)                beat_cnt <= '0;
        else if (out_valid && out_ready) beat_cnt <= beat_cnt + 16'd1;
    end
`endif

endmodule
